// File: rtl/zircon_led_pwm_bank.sv
// zircon_led_pwm_bank -- Avalon-MM LED PWM bank.
//
// This block drives CHANNELS LEDs. Each LED has its own 8-bit duty cycle.
// A shared prescaler and an 8-bit PWM counter form the time base.
// Duty writes go to a shadow register. The shadow is copied to the active
// duty only at a PWM period boundary, so an output never glitches in the
// middle of a period.
//
// Register map (word addresses):
//   0       CTRL      bit0 EN, bit1 INV
//   1       PRESCALE  [PRESC_W-1:0]
//   2       PERIODS   read-only, 16-bit count of completed periods
//   3       reserved
//   4+i     DUTY[i]   [7:0], readback returns the shadow value
//
// Ports:
//   csi_clk        system clock
//   rsi_reset_n    asynchronous active-low reset
//   avs_address    word address
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_read       read strobe
//   avs_readdata   read data, fixed read latency of 1
//   led_out        registered LED drive, one bit per channel

// One PWM lane: shadow duty, active duty and the registered output.
//   wr/wdata  shadow write from the bus
//   load      copy shadow -> active (at a period boundary, or at every
//             cycle while disabled)
//   pwm_cnt   shared PWM counter
//   en/inv    global enable and output polarity
//   shadow    shadow duty, used for readback
//   led       registered output
module zircon_led_pwm_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       load,
  input  logic       en,
  input  logic       inv,
  input  logic [7:0] pwm_cnt,
  output logic [7:0] shadow,
  output logic       led
);
  logic [7:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      led    <= 1'b0;
    end else begin
      if (wr)   shadow <= wdata;
      // The load reads the pre-write shadow. A write that lands on a
      // boundary cycle therefore waits for the next boundary.
      if (load) active <= shadow;
      led <= (en && (pwm_cnt < active)) ^ inv;
    end
  end
endmodule

module zircon_led_pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 4,
  parameter int PRESC_W  = 16
) (
  input  logic                csi_clk,
  input  logic                rsi_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic [CHANNELS-1:0] led_out
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              rd;
    logic [31:0]       wdata;
  } avs_req_t;

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESC   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PERIODS = ADDR_W'(2);

  avs_req_t req;
  assign req = '{addr: avs_address, wr: avs_write, rd: avs_read, wdata: avs_writedata};

  logic                      en, inv;
  logic [PRESC_W-1:0]        presc_p, presc_q;
  logic [7:0]                pwm_cnt;
  logic [15:0]               periods;
  logic                      tick, boundary;
  logic [CHANNELS-1:0]       lane_wr;
  logic [CHANNELS-1:0][7:0]  shadow;
  logic [31:0]               rdata;

  // A tick fires only on an exact match. If P is lowered below the current
  // count, the counter runs on to all-ones and wraps to 0 without a tick.
  assign tick     = en && (presc_q == presc_p);
  assign boundary = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      en      <= 1'b0;
      inv     <= 1'b0;
      presc_p <= '0;
      presc_q <= '0;
      pwm_cnt <= '0;
      periods <= '0;
    end else begin
      if (req.wr && req.addr == A_CTRL) begin
        en  <= req.wdata[0];
        inv <= req.wdata[1];
      end
      if (req.wr && req.addr == A_PRESC) presc_p <= req.wdata[PRESC_W-1:0];

      if (!en) begin
        presc_q <= '0;
        pwm_cnt <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (boundary) periods <= periods + 16'd1;
    end
  end

  // The lanes keep the active duty in step with the shadow while the bank
  // is disabled. The first period after enable then uses the current duties.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    localparam logic [ADDR_W-1:0] LADDR = ADDR_W'(4 + g);
    assign lane_wr[g] = req.wr && (req.addr == LADDR);

    zircon_led_pwm_lane u_lane (
      .clk     (csi_clk),
      .rst_n   (rsi_reset_n),
      .wr      (lane_wr[g]),
      .wdata   (req.wdata[7:0]),
      .load    (boundary || !en),
      .en      (en),
      .inv     (inv),
      .pwm_cnt (pwm_cnt),
      .shadow  (shadow[g]),
      .led     (led_out[g])
    );
  end

  // Readback uses the register values from before this edge. A read and a
  // write to the same address in one cycle therefore return the old value.
  always_comb begin
    rdata = '0;
    if (req.addr == A_CTRL)         rdata = {30'b0, inv, en};
    else if (req.addr == A_PRESC)   rdata = 32'(presc_p);
    else if (req.addr == A_PERIODS) rdata = {16'b0, periods};
    else begin
      for (int i = 0; i < CHANNELS; i++)
        if (req.addr == ADDR_W'(4 + i)) rdata = {24'b0, shadow[i]};
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n)  avs_readdata <= '0;
    else if (req.rd)   avs_readdata <= rdata;
  end
endmodule

// File: tb/tb_zircon_led_pwm_bank.sv
// Directed bench for zircon_led_pwm_bank (CHANNELS=8, ADDR_W=4, PRESC_W=16).
// Inputs are driven on the falling edge. Outputs are sampled on the falling edge.
module tb_zircon_led_pwm_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [7:0]  led;

  int n_vec = 0;
  int n_bad = 0;

  zircon_led_pwm_bank #(.CHANNELS(8), .ADDR_W(4), .PRESC_W(16)) dut (
    .csi_clk       (clk),
    .rsi_reset_n   (rst_n),
    .avs_address   (address),
    .avs_write     (write),
    .avs_writedata (writedata),
    .avs_read      (read),
    .avs_readdata  (readdata),
    .led_out       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  logic [31:0] rv, per0;
  int h0, h1, h2, hx;

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    bus_rd(4'd0, rv); chk("rst_ctrl", rv, 32'h0);
    bus_rd(4'd1, rv); chk("rst_presc", rv, 32'h0);
    bus_rd(4'd2, rv); chk("rst_periods", rv, 32'h0);
    bus_rd(4'd4, rv); chk("rst_duty0", rv, 32'h0);

    // 2: P=0, 256-clock period
    bus_wr(4'd4, 32'h40);
    bus_wr(4'd5, 32'hFF);
    bus_wr(4'd1, 32'h0);
    bus_wr(4'd0, 32'h1);
    h0 = 0; h1 = 0; hx = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (led[0]) h0++;
      if (led[1]) h1++;
      if (led[7:2] != 6'b0) hx++;
    end
    chk("p0_high_ch0", 32'(h0), 32'd64);
    chk("p0_high_ch1", 32'(h1), 32'd255);
    chk("p0_others", 32'(hx), 32'd0);

    // 3: P=3, shadowed duty change mid-period
    bus_wr(4'd0, 32'h0);
    bus_wr(4'd1, 32'h3);
    bus_wr(4'd6, 32'h80);
    bus_rd(4'd1, rv); chk("presc_rb", rv, 32'h3);
    bus_rd(4'd2, per0);
    bus_wr(4'd0, 32'h1);
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 1; k <= 3072; k++) begin
      @(negedge clk);
      if (led[2]) begin
        if (k <= 1024) h0++;
        else if (k <= 2048) h1++;
        else h2++;
      end
      write = 1'b0;
      if (k == 1500) begin
        address = 4'd6; writedata = 32'h10; write = 1'b1;
      end
    end
    chk("p3_high_per0", 32'(h0), 32'd512);
    chk("p3_high_per1", 32'(h1), 32'd512);
    chk("p3_high_per2", 32'(h2), 32'd64);
    bus_rd(4'd2, rv); chk("periods_delta", rv - per0, 32'd3);

    // 4: invert, then disable
    bus_wr(4'd0, 32'h3);
    hx = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (led[3]) hx++;
    end
    chk("inv_ch3_const", 32'(hx), 32'd300);
    bus_wr(4'd0, 32'h2);
    @(negedge clk);
    chk("dis_inv_led", 32'(led), 32'hFF);
    repeat (20) @(negedge clk);
    chk("dis_inv_hold", 32'(led), 32'hFF);
    bus_rd(4'd0, rv); chk("ctrl_rb", rv, 32'h2);

    // 5: read/write collision, out-of-range address
    bus_wr(4'd0, 32'h0);
    bus_wr(4'd9, 32'h11);
    @(negedge clk);
    address = 4'd9; writedata = 32'h22; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("rw_same_old", readdata, 32'h11);
    bus_rd(4'd9, rv); chk("rw_same_new", rv, 32'h22);
    bus_wr(4'd15, 32'hFFFF_FFFF);
    bus_rd(4'd15, rv); chk("addr15", rv, 32'h0);
    bus_wr(4'd3, 32'hFFFF_FFFF);
    bus_rd(4'd3, rv); chk("addr3", rv, 32'h0);
    bus_wr(4'd2, 32'h1234);
    bus_rd(4'd2, rv); chk("periods_ro", rv - per0, 32'd3);

    // 6: restart from pwm_cnt=0, then async reset mid-period
    bus_wr(4'd1, 32'h0);
    bus_wr(4'd0, 32'h1);
    h0 = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (led[0]) h0++;
      if (k == 10) chk("restart_led", 32'(led), 32'h27);
    end
    chk("restart_ch0", 32'(h0), 32'd64);
    chk("active_led", 32'(led), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'h0);
    chk("async_rdata", readdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(4'd0, rv); chk("post_ctrl", rv, 32'h0);
    bus_rd(4'd1, rv); chk("post_presc", rv, 32'h0);
    bus_rd(4'd2, rv); chk("post_periods", rv, 32'h0);
    bus_rd(4'd4, rv); chk("post_duty0", rv, 32'h0);
    bus_rd(4'd9, rv); chk("post_duty5", rv, 32'h0);
    chk("post_led", 32'(led), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
